// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl: sequences a 16-bit add/sub through a 4-bit FA_4bits, LSB nibble first
module nibble_serial_alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cf,
  output logic        of,
  output logic        zf,
  output logic        sf,
  output logic        pf,
  output logic        fa_ctrl,
  output logic [3:0]  fa_a,
  output logic [3:0]  fa_b,
  output logic        fa_c0,
  input  logic [3:0]  fa_s,
  input  logic        fa_cf,
  input  logic        fa_of
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] a_r, b_r;
  logic        op_r, carry, run;
  logic [1:0]  idx;
  assign run     = state == RUN;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign fa_a    = run ? a_r[{idx, 2'b00} +: 4] : 4'd0;
  assign fa_b    = run ? b_r[{idx, 2'b00} +: 4] : 4'd0;
  assign fa_c0   = run & carry;
  assign fa_ctrl = run & op_r;
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (idx == 2'd3 ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= 1'b0;
      idx    <= 2'd0;
      carry  <= 1'b0;
      result <= '0;
      {cf, of, zf, sf, pf} <= '0;
    end else if (state == IDLE && start) begin
      a_r   <= a_in;
      b_r   <= b_in;
      op_r  <= op;
      idx   <= 2'd0;
      carry <= op;
    end else if (run) begin
      result[{idx, 2'b00} +: 4] <= fa_s;
      carry <= fa_cf;
      idx   <= idx + 2'd1;
      if (idx == 2'd3) begin
        cf <= fa_cf;
        of <= fa_of;
        zf <= {fa_s, result[11:0]} == 16'd0;
        sf <= fa_s[3];
        pf <= ~^result[7:0];
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// tb_nibble_serial_alu_ctrl: scoreboard bench with a behavioural FA_4bits attached
module tb_nibble_serial_alu_ctrl;
  logic        clk = 1'b0, rst, start, op;
  logic [15:0] a_in, b_in, result;
  logic        busy, done, cf, of, zf, sf, pf, fa_ctrl, fa_c0, fa_cf, fa_of;
  logic [3:0]  fa_a, fa_b, fa_s, fa_bb;
  logic [4:0]  fa_sum;
  logic [20:0] sb[$];
  int n_cmp = 0, n_fail = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  assign fa_bb  = fa_ctrl ? ~fa_b : fa_b;
  assign fa_sum = {1'b0, fa_a} + {1'b0, fa_bb} + {4'd0, fa_c0};
  assign fa_s   = fa_sum[3:0];
  assign fa_cf  = fa_sum[4];
  assign fa_of  = (fa_a[3] == fa_bb[3]) && (fa_s[3] != fa_a[3]);

  nibble_serial_alu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .cf(cf), .of(of), .zf(zf), .sf(sf), .pf(pf),
    .fa_ctrl(fa_ctrl), .fa_a(fa_a), .fa_b(fa_b), .fa_c0(fa_c0),
    .fa_s(fa_s), .fa_cf(fa_cf), .fa_of(fa_of)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse", 64'(prev_done), 64'd0);
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("result_flags", 64'({result, cf, of, zf, sf, pf}), 64'(sb.pop_front()));
    end
    prev_done <= done;
  end

  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [20:0] e);
    int cyc = 0;
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    sb.push_back(e);
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == 1) chk("fa_c0_nib0", 64'({fa_c0, fa_ctrl}), 64'({o, o}));
    end while (!done && cyc < 20);
    chk("latency", 64'(cyc), 64'd5);
    @(posedge clk);
  endtask

  initial begin
    int cyc, dn, last, seen;
    rst = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({busy, done, result, cf, of, zf, sf, pf, fa_a, fa_b, fa_c0, fa_ctrl}), 64'd0);
    rst = 1'b0;
    run_op(1'b0, 16'hFFFF, 16'h0001, {16'h0000, 5'b10101});
    run_op(1'b0, 16'h7FFF, 16'h0001, {16'h8000, 5'b01011});
    run_op(1'b1, 16'h0005, 16'h0003, {16'h0002, 5'b10000});
    run_op(1'b1, 16'h0003, 16'h0005, {16'hFFFE, 5'b00010});
    run_op(1'b1, 16'h8000, 16'h0001, {16'h7FFF, 5'b11001});
    @(negedge clk);
    op = 1'b0; a_in = 16'h1111; b_in = 16'h2222; start = 1'b1;
    sb.push_back({16'h3333, 5'b00001});
    sb.push_back({16'h6666, 5'b00001});
    dn = 0; last = 0; cyc = 0;
    while (dn < 2 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) a_in = 16'h4444;
      if (done) begin
        dn++;
        if (dn == 1) last = cyc;
        else begin
          chk("done_gap", 64'(cyc - last), 64'd6);
          start = 1'b0;
        end
      end else if (dn == 1 && cyc == last + 1) chk("idle_busy", 64'({busy, done}), 64'd0);
    end
    start = 1'b0;
    chk("held_done_count", 64'(dn), 64'd2);
    @(posedge clk);
    @(negedge clk);
    op = 1'b0; a_in = 16'h1234; b_in = 16'h1111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_abort", 64'({busy, done, result, cf, of, zf, sf, pf, fa_a, fa_b, fa_c0, fa_ctrl}), 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    run_op(1'b0, 16'h1234, 16'h4321, {16'h5555, 5'b00001});
    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_serial_alu_ctrl.md
# nibble_serial_alu_ctrl

Multi-cycle sequencer that performs 16-bit add/subtract by driving the existing 4-bit adder/subtractor (FA_4bits) one nibble per clock, least-significant nibble first. It chains the carry between nibbles. It assembles the 16-bit result and the final flag set (CF, OF, ZF, SF, PF). It sits on both sides of FA_4bits: it feeds the adder's operand and control inputs and consumes its sum and flag outputs. It presents a start/busy/done handshake to the datapath controller above.

## Interface
- No parameters; width fixed at 16 bits (4 nibbles).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = add, 1 = subtract (A − B)
- a_in  in  16  operand A, captured on accepted start
- b_in  in  16  operand B, captured on accepted start
- busy  out  1  high from the cycle after accept until done deasserts
- done  out  1  one-cycle pulse; result and flags valid from this cycle on
- result  out  16  assembled sum/difference
- cf, of, zf, sf, pf  out  1 each  final flags
- fa_ctrl  out  1  to FA_4bits Ctrl (= latched op)
- fa_a, fa_b  out  4  to FA_4bits A/B (current nibble of latched operands)
- fa_c0  out  1  to FA_4bits C0
- fa_s  in  4  from FA_4bits s
- fa_cf, fa_of  in  1  from FA_4bits CF/OF; FA ZF/SF/PF are unused

## Operation
- FA_4bits contract: Ctrl=0 computes A+B+C0; Ctrl=1 computes A+~B+C0. CF is the raw carry-out. OF is signed overflow of the 4-bit operation.
- States:
  - IDLE: start=1 latches a_in, b_in, op; sets idx=0 and carry=op; moves to RUN. start=0 stays in IDLE.
  - RUN: fa_a=A[4·idx+3:4·idx], fa_b likewise, fa_ctrl=op, fa_c0=carry. On each edge, fa_s is written to result[4·idx+3:4·idx] and carry←fa_cf.
    - idx<3: idx increments.
    - idx=3: cf←fa_cf and of←fa_of; zf/sf/pf are computed from the completed 16-bit result; moves to DONE.
  - DONE: done=1 for exactly one cycle, then returns to IDLE.
- Flags:
  - zf = (result==0).
  - sf = result[15].
  - pf = 1 when result[7:0] has an even number of ones.
  - cf is raw; for subtract, cf=1 means no borrow.
- In IDLE and DONE, fa_a/fa_b/fa_c0/fa_ctrl drive 0.
- result and flags hold their values until the next accepted start. They are not cleared at accept; they update nibble-by-nibble during RUN, and flags update only at the idx=3 edge.
- start during RUN or DONE is ignored (no queueing).
- op, a_in and b_in changes after accept have no effect.

## Timing
- Reset values:
  - busy=0, done=0, result=0, cf=of=zf=sf=pf=0.
  - State is IDLE; idx=0; carry=0; fa_* outputs=0.
- Reset asserted in any state aborts the operation within the same edge. It overrides start and does not produce done.
- Latency: start accepted at edge E0; RUN spans edges E1..E4 (nibbles 0..3); done is high in the cycle after E4. That is 5 cycles from start-sample to done.
- busy is high for the 4 RUN cycles plus the DONE cycle. It is low in the cycle done drops.
- Minimum start-to-start spacing is 6 cycles; the next start may be presented in the cycle after done.
- Outputs toward FA_4bits are combinational from registered state. The FA_4bits path plus the result/carry register setup must fit in one clock period.

## Test plan
- Add with full carry ripple: op=0, A=0xFFFF, B=0x0001, with a real FA_4bits attached. Required: result=0x0000, cf=1, zf=1, of=0, sf=0, pf=1. done appears exactly 5 cycles after start-sample.
- Signed overflow: op=0, A=0x7FFF, B=0x0001. Required: result=0x8000, of=1, sf=1, cf=0, zf=0, pf=1.
- Subtract without borrow: op=1, A=0x0005, B=0x0003. Required: result=0x0002, cf=1, of=0, zf=0, pf=0. Check fa_c0=1 on nibble 0.
- Subtract with borrow: op=1, A=0x0003, B=0x0005. Required: result=0xFFFE, cf=0, sf=1, pf=0. Then op=1, A=0x8000, B=0x0001. Required: result=0x7FFF, of=1.
- Protocol: hold start=1 continuously and change a_in mid-RUN. Required: the second operation begins only from IDLE, and the mid-RUN change does not affect the in-flight result. done is a single-cycle pulse each time, and busy is never high together with an accepted start.
- Reset mid-operation: assert rst during RUN at idx=2. Required: the next cycle shows busy=0, done=0, result=0, all flags=0, fa_*=0. No done pulse follows. A fresh start completes normally.
